// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  // Operand width used when the instantiating code does not override it.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa1bit.sv
// One-bit full adder: the only arithmetic element of the serial datapath.
module FA1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: {cout,sum} = op_a + op_b + cin, LSB first,
// one bit per clock through a single FA1bit.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into op_a - op_b (op_b inverted, carry-in forced to 1; cout=1
// means no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Select what goes into the B shift register and carry FF on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = sub ? ~op_b : op_b;
    carry_load = sub ? 1'b1  : cin;
  end
`else
  always_comb begin
    b_load     = op_b;
    carry_load = cin;
  end
`endif

  FA1bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Controller FSM with its datapath registers and registered outputs.
  // NOTE: every register here, shift registers included, is cleared by the
  // async reset so an aborted operation leaves no stale partial state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge; the shift and the adder feedback rely on that.
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= op_a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_co;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic [8:0]  q8  [$];
  logic [16:0] q16 [$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op_a(a16), .op_b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) check("done8_spurious", 32'(done8), 32'd0);
      else check("result8", 32'({cout8, sum8}), 32'(q8.pop_front()));
    end
    if (!rst && done16) begin
      if (q16.size() == 0) check("done16_spurious", 32'(done16), 32'd0);
      else check("result16", 32'({cout16, sum16}), 32'(q16.pop_front()));
    end
  end

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, a} + {1'b0, ~b} + 9'd1;
`endif
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
`endif
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  // Waits (bounded) for done8; counts busy samples seen before it.
  task automatic wait_done8(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) nbusy++;
      @(negedge clk);
    end
  endtask

  // One 8-bit operation; with timing=1 also checks busy length, pulse width, hold.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, input bit timing);
    int nb;
    bit seen;
    logic [8:0] e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    e = ref8(a, b, c, s);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = a ^ b; cin8 = ~c; sub8 = ~s;  // must not disturb the result
    wait_done8(nb, seen);
    check("done8_seen", 32'(seen), 32'd1);
    if (timing) begin
      check("busy8_cycles", 32'(nb), 32'd8);
      @(negedge clk);
      check("done8_one_cycle", 32'(done8), 32'd0);
      @(negedge clk);
      check("sum8_hold", 32'({cout8, sum8}), 32'(e));
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s);
    bit seen;
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; sub16 = s; start16 = 1'b1;
    q16.push_back(ref16(a, b, c, s));
    @(negedge clk);
    start16 = 1'b0;
    a16 = $urandom; b16 = $urandom;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done16) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("done16_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int nb, t_prev, nt;
    bit seen;

    // Reset state.
    #12;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_res8", 32'({cout8, sum8}), 32'd0);
    check("rst_res16", 32'({cout16, sum16}), 32'd0);

    // First start accepted on the first edge after release: 0x35+0x4A.
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(ref8(8'h35, 8'h4A, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("first_accept_busy", 32'(busy8), 32'd1);
    wait_done8(nb, seen);
    check("done8_seen", 32'(seen), 32'd1);
    check("busy8_cycles", 32'(nb), 32'd8);
    check("sum_35_4a", 32'({cout8, sum8}), 32'h07F);

    // Directed additions, including carry-out and wrap.
    run8(8'hFF, 8'h01, 1'b1, 1'b0, 1);
    check("sum_ff_01_c1", 32'({cout8, sum8}), 32'h101);
    run8(8'h00, 8'h00, 1'b0, 1'b0, 1);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1);
    run8(8'h80, 8'h80, 1'b0, 1'b0, 1);
    check("sum_80_80", 32'({cout8, sum8}), 32'h100);

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h10, 8'h03, 1'b0, 1'b1, 1);
    check("sub_10_03", 32'({cout8, sum8}), 32'h10D);
    run8(8'h03, 8'h10, 1'b1, 1'b1, 1);
    check("sub_03_10", 32'({cout8, sum8}), 32'h0F3);
`endif

    // start held high: back-to-back 0x10+0x20, one result every 10 cycles.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 3; k++) q8.push_back(9'h030);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done8(nb, seen);
      check("b2b_done_seen", 32'(seen), 32'd1);
      nt = cyc;
      if (k > 0) check("b2b_period", 32'(nt - t_prev), 32'd10);
      t_prev = nt;
      if (k < 2) @(negedge clk);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_queue_drained", 32'(q8.size()), 32'd0);

    // Reset during RUN cycle 4 aborts; no done afterwards.
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_res", 32'({cout8, sum8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);   // scoreboard flags any stray done
    run8(8'h01, 8'h01, 1'b0, 1'b0, 1);
    check("after_abort_sum", 32'({cout8, sum8}), 32'h002);

    // Random trials at both widths.
    for (int k = 0; k < 1000; k++) begin
      logic s;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s, 0);
    end
    for (int k = 0; k < 1000; k++) begin
      logic s;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), s);
    end
    repeat (3) @(negedge clk);
    check("q8_empty", 32'(q8.size()), 32'd0);
    check("q16_empty", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request an addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  SHALL be operand A, captured on an accepted start.
REQ-006 op_b  input  WIDTH  SHALL be operand B, captured on an accepted start.
REQ-007 cin  input  1  SHALL be the carry-in, captured on an accepted start.
REQ-008 busy  output  1  SHALL be high while in RUN.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when the result is valid.
REQ-010 sum  output  WIDTH  SHALL hold the last completed sum.
REQ-011 cout  output  1  SHALL hold the carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {cout,sum} = op_a + op_b + cin bit-serially, LSB first, one bit per clock through a single 1-bit full adder.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding 2 bits.
REQ-014 IDLE with start=1 SHALL load A/B shift registers, load carry FF with cin, clear bit counter, clear sum register, go to RUN next cycle.
REQ-015 IDLE with start=0 SHALL remain in IDLE with all registers unchanged.
REQ-016 In RUN each cycle SHALL: feed A[0], B[0], carry FF to the full adder; shift adder sum into sum register MSB (shift-right); store adder carry in carry FF; shift A/B right; increment counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the cycle the counter equals WIDTH-1 the FSM SHALL go to DONE.
REQ-018 DONE SHALL assert done for one cycle, drive cout from carry FF, and return unconditionally to IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from the start-accept edge to done high; a new start is accepted the cycle after done.
REQ-020 start asserted during RUN or DONE SHALL be ignored (not queued); operands changing during RUN SHALL not affect the result.
REQ-021 sum and cout SHALL hold their values from DONE until the next accepted start; during RUN sum is undefined-for-use but deterministic (partial shift).
REQ-022 Overflow out of WIDTH bits SHALL appear only on cout; sum wraps modulo 2^WIDTH.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry FF=0, shift registers=0.
REQ-024 rst asserted mid-RUN SHALL abort the operation; no done pulse follows release.
REQ-025 First start is accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add input sub (1 bit, captured on accepted start) and compute op_a - op_b by loading ~op_b and carry FF=1 (cin ignored); cout=1 means no borrow.
REQ-027 Without SERIAL_ADDER_SUB_EN the sub port SHALL not exist and behaviour SHALL be addition only per REQ-012.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 The bit datapath SHALL be one instance of the existing 1-bit full adder module FA1bit; no other sub-modules.
REQ-030 Counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-031 WIDTH=8, op_a=0x35, op_b=0x4A, cin=0, start 1 cycle -> busy 8 cycles, done on cycle 9, sum=0x7F, cout=0.
REQ-032 op_a=0xFF, op_b=0x01, cin=1 -> sum=0x01, cout=1.
REQ-033 start held high continuously, op_a=0x10, op_b=0x20 -> back-to-back results 0x30 every 10 cycles, no start accepted in RUN/DONE.
REQ-034 rst pulsed at RUN cycle 4 -> all outputs 0 immediately, no done afterwards; next start 0x01+0x01 -> sum=0x02.
REQ-035 With SERIAL_ADDER_SUB_EN, sub=1, op_a=0x10, op_b=0x03 -> sum=0x0D, cout=1; op_a=0x03, op_b=0x10 -> sum=0xF3, cout=0.
REQ-036 Random operands, 1000 trials, WIDTH=8 and 16 -> {cout,sum} matches reference a+b+cin every trial.
